// File: rtl/pwm_mixer_nch.sv
// pwm_mixer_nch: N-channel quadrature-encoder level mixer. Each channel
// synchronises and debounces its encoder, then steps a WIDTH-bit level that
// drives a registered PWM output.
// Latency: a level update lands one clock after the debounced A rising edge.
// pwm_out follows the counter value by one clock.
// Backpressure: none. Loads are single-cycle strobes and are always accepted.
// Ports:
//   clk, reset             shared clock and synchronous active-high reset
//   enc_a/enc_b            async encoder phases, one bit per channel
//   mode_saturate          1 clamps the level at 0 and all-ones, 0 wraps
//   load_valid/ch/data     firmware preload of one channel's level
//   level                  channel i level at [i*WIDTH +: WIDTH]
//   pwm_out                registered PWM output, one bit per channel
module pwm_mixer_nch #(
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 8,
  parameter int DEBOUNCE_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enc_a,
  input  logic [CHANNELS-1:0]       enc_b,
  input  logic                      mode_saturate,
  input  logic                      load_valid,
  input  logic [3:0]                load_ch,
  input  logic [WIDTH-1:0]          load_data,
  output logic [CHANNELS*WIDTH-1:0] level,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic [DEBOUNCE_BITS-1:0]       presc_q, presc_d;
  logic [CHANNELS-1:0]            sync_a1_q, sync_a1_d, sync_a2_q, sync_a2_d;
  logic [CHANNELS-1:0]            sync_b1_q, sync_b1_d, sync_b2_q, sync_b2_d;
  logic [CHANNELS-1:0][2:0]       hist_a_q, hist_a_d, hist_b_q, hist_b_d;
  logic [CHANNELS-1:0]            deb_a_q, deb_a_d, deb_b_q, deb_b_d;
  logic [CHANNELS-1:0]            deb_a_prev_q, deb_a_prev_d;
  logic [CHANNELS-1:0][WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic                           strobe;
  logic [CHANNELS-1:0]            rise;

  // Packed [ch][bit] layout already places channel 0 in the low bits.
  assign level   = level_q;
  assign pwm_out = pwm_q;

  always_comb begin
    strobe       = &presc_q;
    presc_d      = presc_q + 1'b1;
    cnt_d        = cnt_q + 1'b1;
    sync_a1_d    = enc_a;
    sync_a2_d    = sync_a1_q;
    sync_b1_d    = enc_b;
    sync_b2_d    = sync_b1_q;
    deb_a_prev_d = deb_a_q;
    hist_a_d     = hist_a_q;
    hist_b_d     = hist_b_q;
    deb_a_d      = deb_a_q;
    deb_b_d      = deb_b_q;
    level_d      = level_q;
    pwm_d        = '0;
    rise         = '0;

    for (int i = 0; i < CHANNELS; i++) begin
      if (strobe) begin
        hist_a_d[i] = {hist_a_q[i][1:0], sync_a2_q[i]};
        hist_b_d[i] = {hist_b_q[i][1:0], sync_b2_q[i]};
      end

      // Hysteresis: only three agreeing samples move the debounced value.
      if (hist_a_q[i] == 3'b111)      deb_a_d[i] = 1'b1;
      else if (hist_a_q[i] == 3'b000) deb_a_d[i] = 1'b0;
      if (hist_b_q[i] == 3'b111)      deb_b_d[i] = 1'b1;
      else if (hist_b_q[i] == 3'b000) deb_b_d[i] = 1'b0;

      // One step per detent: only the rising edge of A counts, B gives direction.
      rise[i] = deb_a_q[i] & ~deb_a_prev_q[i];

      // A load on the same channel overrides and discards a concurrent step.
      if (load_valid && (load_ch == 4'(i))) begin
        level_d[i] = load_data;
      end else if (rise[i]) begin
        if (!deb_b_q[i]) begin
          if (!(mode_saturate && (level_q[i] == {WIDTH{1'b1}})))
            level_d[i] = level_q[i] + 1'b1;
        end else begin
          if (!(mode_saturate && (level_q[i] == '0)))
            level_d[i] = level_q[i] - 1'b1;
        end
      end

      // Strict less-than: level L is high for L of 2^WIDTH clocks.
      pwm_d[i] = (cnt_q < level_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      sync_a1_q    <= '0;
      sync_a2_q    <= '0;
      sync_b1_q    <= '0;
      sync_b2_q    <= '0;
      hist_a_q     <= '0;
      hist_b_q     <= '0;
      deb_a_q      <= '0;
      deb_b_q      <= '0;
      deb_a_prev_q <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      sync_a1_q    <= sync_a1_d;
      sync_a2_q    <= sync_a2_d;
      sync_b1_q    <= sync_b1_d;
      sync_b2_q    <= sync_b2_d;
      hist_a_q     <= hist_a_d;
      hist_b_q     <= hist_b_d;
      deb_a_q      <= deb_a_d;
      deb_b_q      <= deb_b_d;
      deb_a_prev_q <= deb_a_prev_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_mixer_nch.sv
// tb_pwm_mixer_nch: directed bench for pwm_mixer_nch with 3 channels,
// 8-bit levels and a 4-clock debounce strobe. Expected values are
// hand-computed constants.
module tb_pwm_mixer_nch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  enc_a = '0;
  logic [2:0]  enc_b = '0;
  logic        mode_saturate = 1'b0;
  logic        load_valid = 1'b0;
  logic [3:0]  load_ch = '0;
  logic [7:0]  load_data = '0;
  logic [23:0] level;
  logic [2:0]  pwm_out;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int cal_n  = 0;

  pwm_mixer_nch #(
    .CHANNELS(3),
    .WIDTH(8),
    .DEBOUNCE_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .mode_saturate(mode_saturate),
    .load_valid(load_valid),
    .load_ch(load_ch),
    .load_data(load_data),
    .level(level),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [7:0] lvl(input int ch);
    return level[ch*8 +: 8];
  endfunction

  // One detent: CCW raises B before A, CW keeps B low.
  task automatic detent(input int ch, input bit cw);
    if (!cw) begin enc_b[ch] = 1'b1; ticks(32); end
    enc_a[ch] = 1'b1; ticks(32);
    enc_a[ch] = 1'b0; ticks(32);
    enc_b[ch] = 1'b0; ticks(32);
  endtask

  task automatic do_load(input int ch, input logic [7:0] d);
    load_valid = 1'b1;
    load_ch    = 4'(ch);
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pwm_count(input int ch, output int hi);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (pwm_out[ch]) hi++;
    end
  endtask

  task automatic align4();
    while (cyc % 4 != 0) tick();
  endtask

  initial begin
    int bad_l, bad_p, hi;
    logic [23:0] snap;

    // 1: reset then idle
    ticks(5);
    reset = 1'b0;
    bad_l = 0; bad_p = 0;
    for (int k = 0; k < 512; k++) begin
      tick();
      if (level !== 24'd0) bad_l++;
      if (pwm_out !== 3'b000) bad_p++;
    end
    chk("idle_level_bad_cycles", bad_l, 0);
    chk("idle_pwm_bad_cycles", bad_p, 0);

    // 2: five CW detents on ch0
    for (int d = 0; d < 5; d++) detent(0, 1'b1);
    chk("cw5_level_ch0", lvl(0), 5);
    chk("cw5_level_ch1", lvl(1), 0);
    pwm_count(0, hi);
    chk("cw5_pwm_high", hi, 5);

    // 3: saturate vs wrap on ch1
    mode_saturate = 1'b1;
    detent(1, 1'b0);
    chk("sat_ccw_at_0", lvl(1), 0);
    mode_saturate = 1'b0;
    detent(1, 1'b0);
    chk("wrap_ccw_at_0", lvl(1), 255);
    do_load(1, 8'd255);
    mode_saturate = 1'b1;
    detent(1, 1'b1);
    chk("sat_cw_at_255", lvl(1), 255);
    mode_saturate = 1'b0;

    // 4: load ch2 and out-of-range load
    do_load(2, 8'd200);
    chk("load_ch2_next_clk", lvl(2), 200);
    pwm_count(2, hi);
    chk("load_ch2_pwm_high", hi, 200);
    snap = 24'hC8FF05;
    do_load(3, 8'd77);
    tick();
    chk("load_bad_ch_ignored", level, snap);

    // 5: glitch rejection on ch1
    do_load(1, 8'd20);
    enc_a[1] = 1'b1; ticks(3);
    enc_a[1] = 1'b0; ticks(40);
    chk("glitch_3clk_no_step", lvl(1), 20);
    enc_a[1] = 1'b1; ticks(16);
    enc_a[1] = 1'b0; ticks(40);
    chk("pulse_16clk_one_step", lvl(1), 21);

    // 6: find the step edge on ch1 at a known prescaler phase
    align4();
    enc_a[1] = 1'b1;
    cal_n = 0;
    while (lvl(1) == 8'd21 && cal_n < 200) begin
      tick();
      cal_n++;
    end
    chk("cal_step_seen", (cal_n < 200), 1);
    chk("cal_step_value", lvl(1), 22);
    enc_a[1] = 1'b0; ticks(40);

    // Same phase again: load ch1 on exactly the step edge, ch0 steps too.
    if (cal_n < 2 || cal_n >= 200) cal_n = 2;
    align4();
    enc_a[0] = 1'b1;
    enc_a[1] = 1'b1;
    ticks(cal_n - 1);
    do_load(1, 8'd10);
    chk("collide_load_wins", lvl(1), 10);
    chk("collide_other_ch_steps", lvl(0), 6);
    ticks(40);
    enc_a = '0; ticks(40);
    chk("collide_step_dropped", lvl(1), 10);

    // Reset in the middle of a PWM period.
    ticks(100);
    reset = 1'b1;
    tick();
    chk("midrst_level", level, 0);
    chk("midrst_pwm", pwm_out, 0);
    reset = 1'b0;
    ticks(300);
    chk("post_rst_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
